// File: rtl/kmap_pkg.sv
// kmap_pkg: sweep FSM encoding and golden truth tables for the kmap checker.
// Shared by kmap_golden and kmap_sweep_ctrl.
package kmap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [15:0] F0_EXP     = 16'h6996;
  localparam logic [15:0] F1_EXP     = 16'hEDE0;
  localparam logic [15:0] F2_EXP     = 16'hD1CC;
  localparam logic [15:0] F2_DC_MASK = 16'h2222;

endpackage

// File: rtl/kmap_golden.sv
// kmap_golden: combinational idx -> expected F bits and per-output care mask.
// Bit order is {F_2, F_1, F_0}.
module kmap_golden
  import kmap_pkg::*;
(
  input  logic [3:0] idx,
  output logic [2:0] exp_f,
  output logic [2:0] care
);

  assign exp_f = {F2_EXP[idx], F1_EXP[idx], F0_EXP[idx]};
  assign care  = {~F2_DC_MASK[idx], 2'b11};

endmodule

// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl: drives all 16 kmap inputs, samples F_0..F_2, counts bad vectors.
// Optional first-failure capture enabled by defining KMAP_FIRST_ERR_EN.
module kmap_sweep_ctrl
  import kmap_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       F_0,
  input  logic       F_1,
  input  logic       F_2,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt
`ifdef KMAP_FIRST_ERR_EN
  ,
  output logic [3:0] first_err_idx,
  output logic       first_err_vld
`endif
);

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic [3:0] idx;
  logic [2:0] exp_f;
  logic [2:0] care;
  logic       miss;
  logic       settled;
  logic       last;
  logic       accept;

  kmap_golden u_golden (
    .idx   (idx),
    .exp_f (exp_f),
    .care  (care)
  );

  assign miss    = |(({F_2, F_1, F_0} ^ exp_f) & care);
  assign settled = (cnt == 4'(SETTLE_CYC - 1));
  assign last    = (idx == 4'd15);
  assign accept  = (state == IDLE) && start;

  assign {A, B, C, D} = idx;
  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = DRIVE;
      DRIVE:   if (settled) state_n = SAMPLE;
      SAMPLE:  state_n = last ? DONE : DRIVE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          cnt     <= '0;
          idx     <= '0;
          err_cnt <= '0;
          pass    <= 1'b0;
        end
        DRIVE: cnt <= settled ? 4'd0 : cnt + 4'd1;
        SAMPLE: begin
          err_cnt <= err_cnt + 5'(miss);
          // pass must see the last vector's verdict too
          if (last) pass <= (err_cnt == 5'd0) && !miss;
          else      idx  <= idx + 4'd1;
        end
        DONE:    idx <= '0;
        default: ;
      endcase
    end
  end

`ifdef KMAP_FIRST_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else if (accept) begin
      first_err_vld <= 1'b0;
    end else if ((state == SAMPLE) && miss && !first_err_vld) begin
      first_err_idx <= idx;
      first_err_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// tb_kmap_sweep_ctrl: two DUTs (SETTLE_CYC 1 and 3) against a timing-level model.
// Faulty kmap behaviours are injected per instance through mode[].
module tb_kmap_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st[2];
  int         mode[2];
  logic [2:0] f[2];

  wire [3:0] v0, v1;
  wire       b0, b1, d0, d1, p0, p1;
  wire [4:0] e0, e1;
  wire [3:0] fi0, fi1;
  wire       fv0, fv1;

  int checks = 0;
  int errors = 0;

  function automatic logic [2:0] ref_f(int i);
    logic [3:0] b;
    b = i[3:0];
    ref_f[0] = ($countones(b) % 2) == 1;
    ref_f[1] = i inside {5, 6, 7, 8, 10, 11, 13, 14, 15};
    ref_f[2] = i inside {2, 3, 6, 7, 8, 12, 14, 15};
  endfunction

  function automatic bit dc2(int i);
    return i inside {1, 5, 9, 13};
  endfunction

  function automatic logic [2:0] dut_kmap(int m, int i);
    logic [2:0] r;
    r = ref_f(i);
    case (m)
      1: r[0] = 1'b0;
      2: if (dc2(i)) r[2] = ~r[2];
      3: if (i == 10) r[1] = ~r[1];
      4: if (i == 3) r = ~r;
      5: if (i == 0 || i == 15) r[2] = ~r[2];
      default: ;
    endcase
    return r;
  endfunction

  function automatic int sc(int n);
    return (n == 0) ? 1 : 3;
  endfunction

  assign f[0] = dut_kmap(mode[0], int'(v0));
  assign f[1] = dut_kmap(mode[1], int'(v1));

  kmap_sweep_ctrl #(.SETTLE_CYC(1)) u0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (st[0]),
    .F_0     (f[0][0]),
    .F_1     (f[0][1]),
    .F_2     (f[0][2]),
    .A       (v0[3]),
    .B       (v0[2]),
    .C       (v0[1]),
    .D       (v0[0]),
    .busy    (b0),
    .done    (d0),
    .pass    (p0),
    .err_cnt (e0)
`ifdef KMAP_FIRST_ERR_EN
    ,
    .first_err_idx (fi0),
    .first_err_vld (fv0)
`endif
  );

  kmap_sweep_ctrl #(.SETTLE_CYC(3)) u1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (st[1]),
    .F_0     (f[1][0]),
    .F_1     (f[1][1]),
    .F_2     (f[1][2]),
    .A       (v1[3]),
    .B       (v1[2]),
    .C       (v1[1]),
    .D       (v1[0]),
    .busy    (b1),
    .done    (d1),
    .pass    (p1),
    .err_cnt (e1)
`ifdef KMAP_FIRST_ERR_EN
    ,
    .first_err_idx (fi1),
    .first_err_vld (fv1)
`endif
  );

`ifndef KMAP_FIRST_ERR_EN
  assign fi0 = '0;
  assign fi1 = '0;
  assign fv0 = 1'b0;
  assign fv1 = 1'b0;
`endif

  logic [3:0] o_idx[2];
  logic       o_busy[2], o_done[2], o_pass[2], o_fev[2];
  logic [4:0] o_err[2];
  logic [3:0] o_fei[2];
  assign o_idx[0] = v0;  assign o_idx[1] = v1;
  assign o_busy[0] = b0; assign o_busy[1] = b1;
  assign o_done[0] = d0; assign o_done[1] = d1;
  assign o_pass[0] = p0; assign o_pass[1] = p1;
  assign o_err[0] = e0;  assign o_err[1] = e1;
  assign o_fei[0] = fi0; assign o_fei[1] = fi1;
  assign o_fev[0] = fv0; assign o_fev[1] = fv1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: k counts edges since the accepting edge of the current sweep
  bit m_idle[2];
  int m_k[2];
  int m_err[2];
  bit m_pass[2];
  bit m_fev[2];
  int m_fei[2];
  bit fail[2][16];

  initial begin
    for (int n = 0; n < 2; n++) begin
      m_idle[n] = 1; m_k[n] = 0; m_err[n] = 0;
      m_pass[n] = 0; m_fev[n] = 0; m_fei[n] = 0;
    end
  end

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      int s1, len;
      s1 = sc(n) + 1;
      len = 16 * s1;
      if (!rst_n) begin
        m_idle[n] = 1; m_k[n] = 0; m_err[n] = 0;
        m_pass[n] = 0; m_fev[n] = 0; m_fei[n] = 0;
      end else if (m_idle[n]) begin
        if (st[n]) begin
          m_idle[n] = 0; m_k[n] = 0; m_err[n] = 0;
          m_pass[n] = 0; m_fev[n] = 0;
          for (int i = 0; i < 16; i++)
            fail[n][i] = ((dut_kmap(mode[n], i) ^ ref_f(i))
                          & {~dc2(i), 2'b11}) != 3'b000;
        end
      end else begin
        m_k[n]++;
        if (m_k[n] == len + 1) begin
          m_idle[n] = 1;
        end else if (m_k[n] % s1 == 0) begin
          int i;
          i = m_k[n] / s1 - 1;
          if (fail[n][i]) begin
            m_err[n]++;
            if (!m_fev[n]) begin
              m_fev[n] = 1;
              m_fei[n] = i;
            end
          end
          if (m_k[n] == len) m_pass[n] = (m_err[n] == 0);
        end
      end
    end
    #1;
    for (int n = 0; n < 2; n++) begin
      int s1, len, ei;
      bit eb, ed;
      s1 = sc(n) + 1;
      len = 16 * s1;
      eb = !m_idle[n] && m_k[n] < len;
      ed = !m_idle[n] && m_k[n] == len;
      ei = m_idle[n] ? 0 : ((m_k[n] / s1 > 15) ? 15 : m_k[n] / s1);
      chk($sformatf("busy%0d", n), int'(o_busy[n]), int'(eb));
      chk($sformatf("done%0d", n), int'(o_done[n]), int'(ed));
      chk($sformatf("idx%0d", n), int'(o_idx[n]), ei);
      chk($sformatf("err%0d", n), int'(o_err[n]), m_err[n]);
      chk($sformatf("pass%0d", n), int'(o_pass[n]), int'(m_pass[n]));
`ifdef KMAP_FIRST_ERR_EN
      chk($sformatf("fev%0d", n), int'(o_fev[n]), int'(m_fev[n]));
      chk($sformatf("fei%0d", n), int'(o_fei[n]), m_fei[n]);
`endif
    end
  end

  task automatic wait_done(int n, output int cyc);
    bit seen;
    cyc = 0;
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(posedge clk);
      #2;
      cyc++;
      if (o_done[n]) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic sweep(int n, int m, output int cyc);
    mode[n] = m;
    @(negedge clk);
    st[n] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[n] = 1'b0;
    wait_done(n, cyc);
  endtask

  task automatic chk_zero(string nm, int n);
    chk({nm, "_busy"}, int'(o_busy[n]), 0);
    chk({nm, "_done"}, int'(o_done[n]), 0);
    chk({nm, "_idx"}, int'(o_idx[n]), 0);
    chk({nm, "_err"}, int'(o_err[n]), 0);
    chk({nm, "_pass"}, int'(o_pass[n]), 0);
`ifdef KMAP_FIRST_ERR_EN
    chk({nm, "_fei"}, int'(o_fei[n]), 0);
    chk({nm, "_fev"}, int'(o_fev[n]), 0);
`endif
  endtask

  initial begin
    int cyc, pulses, run, maxrun;
    bit found;
    st[0] = 0; st[1] = 0;
    mode[0] = 0; mode[1] = 0;
    repeat (2) @(negedge clk);
    chk_zero("rst0", 0);
    chk_zero("rst1", 1);
    rst_n = 1'b1;

    sweep(0, 0, cyc);
    chk("good_cyc", cyc, 32);
    chk("good_err", int'(e0), 0);
    chk("good_pass", int'(p0), 1);

    sweep(0, 1, cyc);
    chk("f0s0_err", int'(e0), 8);
    chk("f0s0_pass", int'(p0), 0);
`ifdef KMAP_FIRST_ERR_EN
    chk("f0s0_fei", int'(fi0), 1);
`endif

    sweep(0, 2, cyc);
    chk("dc_err", int'(e0), 0);
    chk("dc_pass", int'(p0), 1);

    sweep(1, 3, cyc);
    chk("f1_cyc", cyc, 64);
    chk("f1_err", int'(e1), 1);
    chk("f1_pass", int'(p1), 0);
`ifdef KMAP_FIRST_ERR_EN
    chk("f1_fei", int'(fi1), 10);
`endif

    sweep(0, 4, cyc);
    chk("multi_err", int'(e0), 1);

    sweep(0, 5, cyc);
    chk("edge_err", int'(e0), 2);
`ifdef KMAP_FIRST_ERR_EN
    chk("edge_fei", int'(fi0), 0);
`endif

    mode[0] = 0;
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[0] = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (v0 == 4'd7) found = 1;
      else @(negedge clk);
    end
    chk("idx7_reached", int'(found), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst", 0);
    @(negedge clk);
    rst_n = 1'b1;
    st[0] = 1'b1;
    @(posedge clk);
    #2 chk("accept_after_rst", int'(b0), 1);
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0, cyc);
    chk("rst_cyc", cyc, 32);
    chk("rst_pass", int'(p0), 1);

    @(negedge clk);
    st[0] = 1'b1;
    pulses = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 110; c++) begin
      @(posedge clk);
      #2;
      if (d0) begin
        run++;
        if (run == 1) pulses++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    @(negedge clk);
    st[0] = 1'b0;
    chk("held_pulses", pulses, 3);
    chk("held_pulse_len", maxrun, 1);
    wait_done(0, cyc);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
